// File: rtl/i2s_rx_axis.sv
// Slave I2S receiver: oversamples bclk/lrclk/sdata in the aclk domain, assembles 16-bit L/R words
// and streams {L,R} frames through a small first-word-fall-through FIFO onto AXI-Stream.
`timescale 1ns/1ps
module i2s_rx_axis #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH        = 8,
  parameter int FRAME_LEN         = 256,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         i2s_bclk,
  input  logic                         i2s_lrclk,
  input  logic                         i2s_sdata,
  input  logic                         enable,
  input  logic                         clear_status,
  output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         overflow,
  output logic                         short_slot
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int EW  = C_AXIS_DATA_WIDTH + 1;

  typedef enum logic {IDLE, CAPTURE} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q, sdata_sync_q;
  logic sync_bclk, sync_lrclk, sync_sdata;
  logic bclk_d_q, lr_prev_q;
  logic bclk_rise, lr_chg;

  state_t state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d, cnt_step;
  logic [15:0] shreg_q, shreg_d, shreg_step;
  logic [15:0] l_word_q, l_word_d, word;
  logic        push_req, short_set;
  logic [C_AXIS_DATA_WIDTH-1:0] push_data;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic [FCW-1:0] frame_cnt_q;
  logic           full, push_ok, pop, push_last;
  logic           overflow_q, short_slot_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_d_q     <= 1'b0;
      lr_prev_q    <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], i2s_sdata};
      bclk_d_q     <= sync_bclk;
      if (bclk_rise) lr_prev_q <= sync_lrclk;
    end
  end

  assign sync_bclk  = bclk_sync_q[SYNC_STAGES-1];
  assign sync_lrclk = lrclk_sync_q[SYNC_STAGES-1];
  assign sync_sdata = sdata_sync_q[SYNC_STAGES-1];
  assign bclk_rise  = sync_bclk & ~bclk_d_q;
  assign lr_chg     = bclk_rise & (sync_lrclk != lr_prev_q);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      l_word_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      l_word_q  <= l_word_d;
    end
  end

  // The shift and the word-complete test share one bclk edge, so the LSB of a
  // 16-bit slot, which arrives on the lrclk change edge, still lands in the word.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    l_word_d   = l_word_q;
    cnt_step   = bit_cnt_q;
    shreg_step = shreg_q;
    word       = '0;
    push_req   = 1'b0;
    push_data  = '0;
    short_set  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (lr_chg && !sync_lrclk) begin
            state_d   = CAPTURE;
            bit_cnt_d = '0;
          end
        end
        CAPTURE: begin
          if (bclk_rise) begin
            if (bit_cnt_q < 5'd16) begin
              shreg_step = {shreg_q[14:0], sync_sdata};
              cnt_step   = bit_cnt_q + 5'd1;
            end
            shreg_d   = shreg_step;
            bit_cnt_d = cnt_step;
            if (lr_chg) begin
              word      = shreg_step << (5'd16 - cnt_step);
              short_set = (cnt_step < 5'd16);
              if (!lr_prev_q) begin
                l_word_d = word;
              end else begin
                push_req  = 1'b1;
                push_data = {l_word_q, word};
              end
              bit_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO is lost
  // even when a beat leaves in the same cycle.
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push_ok   = push_req & ~full;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign push_last = (frame_cnt_q == FCW'(FRAME_LEN - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_last, push_data};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q    <= wr_ptr_q + AW'(1);
        frame_cnt_q <= push_last ? '0 : frame_cnt_q + FCW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_q   <= 1'b0;
      short_slot_q <= 1'b0;
    end else begin
      overflow_q   <= (push_req & full) | (overflow_q & ~clear_status);
      short_slot_q <= short_set | (short_slot_q & ~clear_status);
    end
  end

  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign overflow      = overflow_q;
  assign short_slot    = short_slot_q;

endmodule
